// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared definitions for the I/D memory arbiter.
// Holds the FSM state encoding, block geometry, memory latency and the
// fill-address helper used by mem_arbiter and fill_counter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_I_FILL  = 2'd1,
    ST_D_FILL  = 2'd2,
    ST_D_WRITE = 2'd3
  } state_t;

  localparam int BLOCK_WORDS = 8;
  localparam int MEM_LATENCY = 4;
  localparam int WORD_BYTES  = 2;

  localparam int IDX_W = $clog2(BLOCK_WORDS);
  localparam int OFS_W = $clog2(WORD_BYTES);
  // Number of address bits that identify a block.
  localparam int BLK_W = 16 - IDX_W - OFS_W;

  // last_grant encoding.
  localparam logic GRANT_I = 1'b0;
  localparam logic GRANT_D = 1'b1;

  // Word address inside a block: block base, word index, zero byte offset.
  function automatic logic [15:0] fill_addr(input logic [BLK_W-1:0] blk,
                                            input logic [IDX_W-1:0] idx);
    return {blk, idx, {OFS_W{1'b0}}};
  endfunction

endpackage

// File: rtl/fill_counter.sv
// fill_counter: word counter for one block, with clear/enable and a
// terminal-count flag raised while the count sits on the last word.
// Ports: clk, rst (sync, active-high), clr, en -> cnt, tc.
module fill_counter
  import mem_arb_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [IDX_W-1:0] cnt,
  output logic             tc
);

  assign tc = (cnt == IDX_W'(BLOCK_WORDS - 1));

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one main-memory port between an I-cache (block fills)
// and a D-cache (block fills or single-word writes) with alternating priority.
// Ports: clk, rst; i_req/i_addr; d_req/d_wr/d_addr/d_wdata; grants, valids,
// dones, fill_data/fill_idx; mem_addr/mem_en/mem_wr/mem_wdata; mem_rdata/mem_valid.
module mem_arbiter
  import mem_arb_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [15:0] i_addr,
  input  logic        d_req,
  input  logic        d_wr,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  output logic        i_grant,
  output logic        d_grant,
  output logic        i_valid,
  output logic        d_valid,
  output logic        i_done,
  output logic        d_done,
  output logic [15:0] fill_data,
  output logic [2:0]  fill_idx,
  output logic [15:0] mem_addr,
  output logic        mem_en,
  output logic        mem_wr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_valid
);

  state_t           state;
  state_t           state_nx;
  logic             last_grant;
  logic [BLK_W-1:0] blk_q;
  logic             issue_done;

  logic             pick_d;
  logic             pick_i;
  logic             fill_st;
  logic             issue_en;
  logic             recv_en;
  logic             cnt_clr;
  logic [IDX_W-1:0] issue_cnt;
  logic [IDX_W-1:0] recv_cnt;
  logic             issue_tc;
  logic             recv_tc;

  // Byte offset within the block is irrelevant to I fills.
  logic unused_i_addr_lsb;
  assign unused_i_addr_lsb = ^i_addr[15-BLK_W:0];

  // D has priority on contention unless it won the previous transaction.
  assign pick_d   = d_req && (!i_req || (last_grant == GRANT_I));
  assign pick_i   = i_req && !pick_d;

  assign fill_st  = (state == ST_I_FILL) || (state == ST_D_FILL);
  // Reads are issued back to back until all words are out; the receive side
  // runs independently, driven only by returning data.
  assign issue_en = fill_st && !issue_done;
  assign recv_en  = fill_st && mem_valid;
  assign cnt_clr  = (state == ST_IDLE);

  fill_counter u_issue_cnt (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .en  (issue_en),
    .cnt (issue_cnt),
    .tc  (issue_tc)
  );

  fill_counter u_recv_cnt (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .en  (recv_en),
    .cnt (recv_cnt),
    .tc  (recv_tc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      last_grant <= GRANT_I;
      blk_q      <= '0;
      issue_done <= 1'b0;
    end else begin
      state <= state_nx;
      if ((state == ST_IDLE) && (pick_d || pick_i)) begin
        last_grant <= pick_d ? GRANT_D : GRANT_I;
        blk_q      <= pick_d ? d_addr[15:16-BLK_W] : i_addr[15:16-BLK_W];
      end
      // The issue counter wraps after the last word; this flag stops further reads.
      if (cnt_clr) begin
        issue_done <= 1'b0;
      end else if (issue_en && issue_tc) begin
        issue_done <= 1'b1;
      end
    end
  end

  always_comb begin
    state_nx  = state;
    i_grant   = 1'b0;
    d_grant   = 1'b0;
    i_valid   = 1'b0;
    d_valid   = 1'b0;
    i_done    = 1'b0;
    d_done    = 1'b0;
    fill_data = '0;
    fill_idx  = '0;
    mem_addr  = '0;
    mem_en    = 1'b0;
    mem_wr    = 1'b0;
    mem_wdata = '0;

    case (state)
      ST_IDLE: begin
        if (pick_d) begin
          state_nx = d_wr ? ST_D_WRITE : ST_D_FILL;
        end else if (pick_i) begin
          state_nx = ST_I_FILL;
        end
      end

      ST_I_FILL, ST_D_FILL: begin
        i_grant = (state == ST_I_FILL);
        d_grant = (state == ST_D_FILL);
        if (issue_en) begin
          mem_en   = 1'b1;
          mem_addr = fill_addr(blk_q, issue_cnt);
        end
        if (mem_valid) begin
          fill_data = mem_rdata;
          fill_idx  = recv_cnt;
          i_valid   = (state == ST_I_FILL);
          d_valid   = (state == ST_D_FILL);
          // Last word closes the transaction in the cycle it arrives.
          if (recv_tc) begin
            i_done   = (state == ST_I_FILL);
            d_done   = (state == ST_D_FILL);
            state_nx = ST_IDLE;
          end
        end
      end

      ST_D_WRITE: begin
        d_grant   = 1'b1;
        d_done    = 1'b1;
        mem_en    = 1'b1;
        mem_wr    = 1'b1;
        mem_addr  = d_addr;
        mem_wdata = d_wdata;
        state_nx  = ST_IDLE;
      end

      default: state_nx = ST_IDLE;
    endcase
  end

endmodule
